sample_frame_ctrl: RTL and testbench
====================================

# sample_frame_ctrl

Sequencer for the 1024 x 16 test-signal sample ROM. It accepts a frame request (base address, length, loop flag) and drives the ROM address port. It tracks the ROM's 1-cycle registered read latency and delivers samples as a valid/ready stream with a last-sample marker. It sits between the sample ROM and the downstream filter pipeline and absorbs filter backpressure, so no sample is lost or duplicated.

## Interface
Parameters:
- ADDR_W, 10, ROM address width (ROM depth 2^ADDR_W)
- DATA_W, 16, sample width
- BUF_DEPTH, 4, output buffer entries (power of 2, >= 4)

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset_n  in  1  reset, asynchronous and active-low
- start  in  1  frame request; sampled only in IDLE
- base_addr  in  ADDR_W  first ROM address of the frame
- frame_len  in  ADDR_W+1  samples per frame; 0 = invalid, values > 2^ADDR_W clamp to 2^ADDR_W
- loop_en  in  1  repeat the frame until abort
- abort  in  1  stop the current frame and flush
- rom_addr  out  ADDR_W  address to the ROM (registered)
- rom_data  in  DATA_W  ROM read data; valid the cycle after rom_addr
- out_data  out  DATA_W  sample to the filter
- out_valid  out  1  out_data valid
- out_ready  in  1  filter accepts the sample
- out_last  out  1  qualifies the final sample of each frame
- busy  out  1  high while not IDLE
- done  out  1  one-cycle pulse when the final sample of a non-loop frame is accepted

## Operation
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: rom_addr=0, out_data=0, out_valid=0, out_last=0, busy=0, done=0, buffer empty, FSM=IDLE.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE to RUN: start=1 and frame_len!=0. base_addr, clamped frame_len and loop_en are latched.
  - start with frame_len=0: ignored; stays IDLE, no done.
  - RUN to DRAIN: the last address of a non-loop frame has been issued.
  - DRAIN to IDLE: buffer empty, nothing in flight, final sample accepted. done pulses in the accepting cycle.
- Issue rule: an address is issued in a cycle only if (buffer occupancy + reads in flight - pop this cycle) < BUF_DEPTH. A 1-bit valid pipeline, parallel to the ROM latency, tags in-flight reads.
- Address generation: offset counter 0..len-1; rom_addr = (base + offset) mod 2^ADDR_W.
  - Wraps 1023 to 0 with no gap.
  - rom_addr holds when no read is issued. The resulting re-reads are untagged and discarded.
- Loop mode: after the last offset, the offset returns to 0 and issuing continues with no bubble. out_last is set on each frame's final sample. done never pulses. Only abort exits.
- Buffer: BUF_DEPTH-entry FIFO; each entry is sample plus last flag. out_data/out_valid/out_last come from the FIFO head.
- Handshake:
  - A sample transfers when out_valid && out_ready.
  - While out_ready=0, out_data and out_last are held stable.
  - out_valid never drops without a transfer, except on abort or reset.
- abort (any state except IDLE):
  - Next cycle: FSM=IDLE, buffer flushed, in-flight tags cleared, out_valid=0, busy=0, no done.
  - Takes priority over simultaneous start, issue and pop.
- start while busy: ignored.
- Reset mid-frame: immediate return to reset values; no residual samples after reset release.

## Timing
- start=1 in cycle 0 gives the following:
  - busy=1 in cycle 1.
  - rom_addr=base in cycle 1.
  - rom_data valid in cycle 2.
  - out_valid=1 with sample[base] in cycle 3.
- Steady state with out_ready=1: one sample per cycle, including across address wrap and loop restart.
- A len-N non-loop frame with out_ready=1: last transfer in cycle N+2, done=1 in that cycle, busy=0 in cycle N+3.
- Backpressure: after out_ready deasserts, at most BUF_DEPTH samples are buffered and issuing stalls. Resumption restarts transfers in the same cycle out_ready rises.
- All outputs are registered; no combinational path from out_ready to rom_addr beyond the issue-enable logic.

## Test plan
- ROM[i]=i, base=0, len=4, out_ready=1 -> out_data 0,1,2,3 in cycles 3-6, out_last with 3, done in cycle 6.
- base=1022, len=4 -> rom_addr 1022,1023,0,1; out_data 1022,1023,0,1, no bubble.
- len=16, out_ready toggling pseudo-randomly -> exactly 16 transfers, values base..base+15 in order, data stable while stalled.
- loop_en=1, base=5, len=3, run 10 samples then abort -> 5,6,7,5,6,7,5,6,7,5 with out_last on each 7; out_valid=0 and busy=0 the cycle after abort; done never asserted.
- len=0 start -> stays IDLE; len=2000 -> exactly 1024 samples, done once.
- reset_n low mid-frame (sample 7 of 32) -> all outputs at reset values immediately; a new start afterwards streams from base cleanly.

Source files
------------

// File: rtl/sample_frame_ctrl.sv
// sample_frame_ctrl: walks a frame of addresses through the sample ROM, tags the
// 1-cycle ROM read latency, and buffers returned samples into a valid/ready stream
// with a per-frame last marker. Issue is throttled so the buffer can never overflow.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   ST_IDLE  | waiting for start; buffer empty, nothing in flight
//   ST_RUN   | issuing frame addresses (wraps to offset 0 in loop mode)
//   ST_DRAIN | all addresses issued; waiting for the final sample to leave
module sample_frame_ctrl #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 16,
  parameter int BUF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   frame_len,
  input  logic              loop_en,
  input  logic              abort,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OCC_W = CNT_W + 1;
  localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(BUF_DEPTH);
  localparam logic [ADDR_W:0]  MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W-1:0]   len_m1_q, len_m1_d;
  logic                loop_q, loop_d;
  logic [ADDR_W-1:0]   off_q, off_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic                tag1_q, tag1_d, last1_q, last1_d;
  logic                tag2_q, tag2_d, last2_q, last2_d;
  logic [DATA_W-1:0]   mem_q [BUF_DEPTH];
  logic [DATA_W-1:0]   mem_d [BUF_DEPTH];
  logic [BUF_DEPTH-1:0] lmem_q, lmem_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;

  logic              pop, push, issue_ok, frame_final;
  logic [OCC_W-1:0]  occ;
  logic [ADDR_W:0]   len_eff;
  logic [ADDR_W-1:0] start_m1;

  assign out_valid = (count_q != '0);
  assign out_data  = mem_q[rd_ptr_q];
  assign out_last  = lmem_q[rd_ptr_q] & out_valid;
  assign busy      = (state_q != ST_IDLE);
  assign rom_addr  = rom_addr_q;
  assign done      = frame_final & ~abort;

  // Handshake bookkeeping and the slot reservation that keeps the buffer from overflowing.
  always_comb begin
    pop         = out_valid & out_ready;
    push        = tag2_q;
    occ         = OCC_W'(count_q) + OCC_W'(tag1_q) + OCC_W'(tag2_q) - OCC_W'(pop);
    issue_ok    = (occ < DEPTH_C);
    frame_final = (state_q == ST_DRAIN) && pop && (count_q == CNT_W'(1)) && !tag1_q && !tag2_q;
    len_eff     = (frame_len > MAX_LEN) ? MAX_LEN : frame_len;
    start_m1    = ADDR_W'(len_eff - (ADDR_W+1)'(1));
  end

  // Next-state: FSM, address generation, read-tag pipeline and FIFO; abort overrides all.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_m1_d   = len_m1_q;
    loop_d     = loop_q;
    off_d      = off_q;
    rom_addr_d = rom_addr_q;
    tag1_d     = 1'b0;
    last1_d    = 1'b0;
    tag2_d     = tag1_q;
    last2_d    = last1_q;
    mem_d      = mem_q;
    lmem_d     = lmem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    case (state_q)
      ST_IDLE: begin
        if (start && (frame_len != '0) && !abort) begin
          base_d     = base_addr;
          len_m1_d   = start_m1;
          loop_d     = loop_en;
          rom_addr_d = base_addr;
          tag1_d     = 1'b1;
          last1_d    = (start_m1 == '0);
          off_d      = (start_m1 == '0) ? '0 : ADDR_W'(1);
          state_d    = ((start_m1 == '0) && !loop_en) ? ST_DRAIN : ST_RUN;
        end
      end
      ST_RUN: begin
        if (issue_ok) begin
          rom_addr_d = base_q + off_q;
          tag1_d     = 1'b1;
          last1_d    = (off_q == len_m1_q);
          if (off_q == len_m1_q) begin
            off_d = '0;
            if (!loop_q) state_d = ST_DRAIN;
          end else begin
            off_d = off_q + ADDR_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (frame_final) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (push) begin
      mem_d[wr_ptr_q]  = rom_data;
      lmem_d[wr_ptr_q] = last2_q;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    if (abort) begin
      state_d  = ST_IDLE;
      tag1_d   = 1'b0;
      last1_d  = 1'b0;
      tag2_d   = 1'b0;
      last2_d  = 1'b0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      len_m1_q   <= '0;
      loop_q     <= 1'b0;
      off_q      <= '0;
      rom_addr_q <= '0;
      tag1_q     <= 1'b0;
      last1_q    <= 1'b0;
      tag2_q     <= 1'b0;
      last2_q    <= 1'b0;
      for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
      lmem_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_m1_q   <= len_m1_d;
      loop_q     <= loop_d;
      off_q      <= off_d;
      rom_addr_q <= rom_addr_d;
      tag1_q     <= tag1_d;
      last1_q    <= last1_d;
      tag2_q     <= tag2_d;
      last2_q    <= last2_d;
      mem_q      <= mem_d;
      lmem_q     <= lmem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

endmodule

// File: tb/tb_sample_frame_ctrl.sv
// Bench for sample_frame_ctrl: registered ROM model, random backpressure, and a
// scoreboard of expected samples consumed by an independent negedge monitor.
module tb_sample_frame_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, loop_en, abort, out_ready;
  logic [9:0]  base_addr;
  logic [10:0] frame_len;
  logic [9:0]  rom_addr;
  logic [15:0] rom_data = '0;
  logic [15:0] out_data;
  logic        out_valid, out_last, busy, done;

  sample_frame_ctrl #(.ADDR_W(10), .DATA_W(16), .BUF_DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .frame_len(frame_len), .loop_en(loop_en), .abort(abort), .rom_addr(rom_addr),
    .rom_data(rom_data), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rom_fn(input int a);
    return 16'(a) ^ 16'h5A00;
  endfunction

  always @(posedge clk) rom_data <= rom_fn(int'(rom_addr));

  typedef struct {
    logic [15:0] d;
    logic        l;
    logic        dn;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   xfer_cnt = 0;
  bit   done_seen = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // Monitor: consumes the scoreboard on every transfer, checks done and stall stability.
  bit          stall_prev = 0, abort_prev = 0;
  logic [15:0] data_prev;
  logic        last_prev;
  always @(negedge clk) begin
    if (!reset_n) begin
      stall_prev = 0;
    end else begin
      if (stall_prev && !abort_prev) begin
        check("stall_valid", int'(out_valid), 1);
        check("stall_data", int'(out_data), int'(data_prev));
        check("stall_last", int'(out_last), int'(last_prev));
      end
      if (done && !(out_valid && out_ready)) check("done_spurious", int'(done), 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL xfer_unexpected: data %0d with empty scoreboard", out_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_data", int'(out_data), int'(e.d));
          check("out_last", int'(out_last), int'(e.l));
          check("done", int'(done), int'(e.dn));
        end
        xfer_cnt++;
      end
      if (done) done_seen = 1;
      stall_prev = out_valid && !out_ready;
      data_prev  = out_data;
      last_prev  = out_last;
      abort_prev = abort;
    end
  end

  // Non-loop frame; entered and left just after a rising edge.
  task automatic run_frame(input int base, input int len, input bit rnd);
    int n, rel;
    n = (len > 1024) ? 1024 : len;
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.d  = rom_fn((base + i) % 1024);
      e.l  = (i == n - 1);
      e.dn = (i == n - 1);
      exp_q.push_back(e);
    end
    done_seen = 0;
    out_ready = 1'b1;
    start = 1'b1; base_addr = 10'(base); frame_len = 11'(len); loop_en = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    rel = 1;
    check("busy_cycle1", int'(busy), 1);
    if (!rnd) check("rom_addr_cycle1", int'(rom_addr), base);
    while (!done_seen && rel < 6000) begin
      if (rnd) out_ready = ($urandom_range(0, 3) != 0);
      if (!rnd && rel == 2) check("valid_cycle2", int'(out_valid), 0);
      if (!rnd && rel == 3) check("valid_cycle3", int'(out_valid), 1);
      @(posedge clk); #1;
      rel++;
    end
    check("frame_done_seen", int'(done_seen), 1);
    if (!rnd) check("done_cycle", rel - 1, n + 2);
    check("busy_after_done", int'(busy), 0);
    check("scoreboard_empty", exp_q.size(), 0);
    out_ready = 1'b1;
  endtask

  initial begin
    int x0, b;
    reset_n = 1'b0; start = 1'b0; loop_en = 1'b0; abort = 1'b0; out_ready = 1'b1;
    base_addr = '0; frame_len = '0;
    #1;
    check("rst_rom_addr", int'(rom_addr), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_last", int'(out_last), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    run_frame(0, 4, 0);
    run_frame(1022, 4, 0);
    run_frame(int'($urandom_range(0, 1023)), 16, 1);
    run_frame(1, 1, 0);

    // Loop frame, ten samples, then abort.
    for (int i = 0; i < 10; i++) begin
      exp_t e;
      e.d  = rom_fn(5 + (i % 3));
      e.l  = ((i % 3) == 2);
      e.dn = 1'b0;
      exp_q.push_back(e);
    end
    done_seen = 0;
    x0 = xfer_cnt;
    start = 1'b1; base_addr = 10'd5; frame_len = 11'd3; loop_en = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (xfer_cnt - x0 >= 10) break;
    end
    check("loop_xfers", xfer_cnt - x0, 10);
    abort = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    abort = 1'b0; loop_en = 1'b0;
    check("abort_valid", int'(out_valid), 0);
    check("abort_busy", int'(busy), 0);
    check("loop_no_done", int'(done_seen), 0);
    check("loop_scoreboard", exp_q.size(), 0);
    out_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check("abort_quiet_valid", int'(out_valid), 0);

    // Zero length is ignored.
    start = 1'b1; base_addr = 10'd9; frame_len = 11'd0;
    @(posedge clk); #1;
    start = 1'b0;
    check("len0_busy1", int'(busy), 0);
    repeat (2) begin @(posedge clk); #1; end
    check("len0_busy3", int'(busy), 0);
    check("len0_valid3", int'(out_valid), 0);

    run_frame(int'($urandom_range(0, 1023)), 2000, 0);

    // Reset in the middle of a 32-sample frame.
    b = int'($urandom_range(0, 1023));
    for (int i = 0; i < 32; i++) begin
      exp_t e;
      e.d = rom_fn((b + i) % 1024); e.l = (i == 31); e.dn = (i == 31);
      exp_q.push_back(e);
    end
    x0 = xfer_cnt;
    start = 1'b1; base_addr = 10'(b); frame_len = 11'd32; loop_en = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (xfer_cnt - x0 >= 7) break;
      out_ready = ($urandom_range(0, 2) != 0);
    end
    check("pre_reset_xfers", xfer_cnt - x0, 7);
    #1 reset_n = 1'b0;
    #1;
    check("mid_rst_rom_addr", int'(rom_addr), 0);
    check("mid_rst_out_data", int'(out_data), 0);
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_out_last", int'(out_last), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_done", int'(done), 0);
    exp_q.delete();
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_valid", int'(out_valid), 0);
    run_frame(int'($urandom_range(0, 1023)), 8, 0);

    for (int k = 0; k < 4; k++)
      run_frame(int'($urandom_range(0, 1023)), int'($urandom_range(1, 40)), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
